// File: rtl/wb_uart_prog_pkg.sv
// Shared definitions for the Wishbone-programmed UART transmitter.
package wb_uart_prog_pkg;

    // Register offsets, indexed by adr[3:2]
    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    // Serialiser states
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    // CTRL bit positions; cpb occupies [15:0]
    localparam int unsigned CTRL_TX_EN  = 16;
    localparam int unsigned CTRL_IRQ_EN = 17;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_LEVEL_LSB = 4;
    localparam int unsigned STAT_OVERFLOW  = 8;

endpackage

// File: rtl/wb_uart_prog_fifo.sv
// Synchronous byte FIFO; head is visible on o_data while not empty.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module wb_uart_prog_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned LW = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    // Full/empty come from the pre-edge count, so a push at full is dropped
    // even when a pop happens on the same edge.
    assign o_full  = (r_count == LW'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_wr_en = i_push & ~o_full;
    assign w_rd_en = i_pop & ~o_empty;

    // Storage write; contents need no reset
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_uart_prog_tx.sv
// Wishbone responder that buffers firmware bytes and shifts them out as
// UART 8N1 with a programmable bit time.
module wb_uart_prog_tx
    import wb_uart_prog_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] CPB_RESET  = 16'd868
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        uart_tx_o,
    output logic        irq_o
);

    localparam int unsigned LW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    logic          w_hit, w_acc, w_wr, w_rd, w_push, w_pop;
    logic [1:0]    w_off;
    logic [31:0]   w_rdata;
    logic          r_ack;
    logic [31:0]   r_dat;
    logic [15:0]   r_cpb;
    logic          r_tx_en, r_irq_en, r_ovf, r_irq;
    logic          w_full, w_empty;
    logic [7:0]    w_head;
    logic [LW-1:0] w_level;
    tx_state_e     r_state, w_state_d;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bit_idx;
    logic [15:0]   r_cnt, r_bit_time;
    logic          w_bit_done, w_start, w_uart_tx;
    logic          w_unused;

    assign w_hit  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_acc  = w_hit & ~r_ack;
    assign w_wr   = w_acc & wbs_we_i;
    assign w_rd   = w_acc & ~wbs_we_i;
    assign w_off  = wbs_adr_i[3:2];
    assign w_push = w_wr & (w_off == ADDR_TXDATA) & wbs_sel_i[0];
    assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i[31:18], wbs_sel_i[3]};

    wb_uart_prog_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push),
        .i_data  (wbs_dat_i[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Read data multiplexer
    always_comb begin
        w_rdata = '0;
        case (w_off)
            ADDR_CTRL: begin
                w_rdata[15:0]        = r_cpb;
                w_rdata[CTRL_TX_EN]  = r_tx_en;
                w_rdata[CTRL_IRQ_EN] = r_irq_en;
            end
            ADDR_STATUS: begin
                w_rdata[STAT_BUSY]                         = (r_state != IDLE);
                w_rdata[STAT_FULL]                         = w_full;
                w_rdata[STAT_EMPTY]                        = w_empty;
                w_rdata[STAT_LEVEL_LSB+3:STAT_LEVEL_LSB]   = 4'(w_level);
                w_rdata[STAT_OVERFLOW]                     = r_ovf;
            end
            default: ;
        endcase
    end

    // Bus handshake, control registers, sticky overflow and registered irq
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_cpb    <= CPB_RESET;
            r_tx_en  <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_rd ? w_rdata : '0;
            if (w_wr && (w_off == ADDR_CTRL)) begin
                if (wbs_sel_i[0]) r_cpb[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) r_cpb[15:8] <= wbs_dat_i[15:8];
                if (wbs_sel_i[2]) begin
                    r_tx_en  <= wbs_dat_i[CTRL_TX_EN];
                    r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
                end
            end
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_off == ADDR_STATUS) && wbs_sel_i[1] &&
                         wbs_dat_i[STAT_OVERFLOW]) begin
                r_ovf <= 1'b0;
            end
            r_irq <= r_irq_en & w_empty & (r_state == IDLE);
        end
    end

    assign w_start    = (r_state == IDLE) & r_tx_en & ~w_empty;
    assign w_pop      = w_start;
    assign w_bit_done = (r_cnt == r_bit_time - 16'd1);

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_d = START;
            START:   if (w_bit_done) w_state_d = DATA;
            DATA:    if (w_bit_done && (r_bit_idx == 3'd7)) w_state_d = STOP;
            STOP:    if (w_bit_done) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Shift register, bit index and bit-time counter; cpb is frozen per frame
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_cnt      <= '0;
            r_bit_time <= 16'd1;
        end else if (w_start) begin
            r_shreg    <= w_head;
            r_bit_idx  <= '0;
            r_cnt      <= '0;
            r_bit_time <= (r_cpb == 16'd0) ? 16'd1 : r_cpb;
        end else if (r_state != IDLE) begin
            if (w_bit_done) begin
                r_cnt <= '0;
                if (r_state == DATA) begin
                    r_shreg   <= {1'b0, r_shreg[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // FSM output decode; reset forces IDLE so the line goes high at once
    always_comb begin
        w_uart_tx = 1'b1;
        case (r_state)
            START:   w_uart_tx = 1'b0;
            DATA:    w_uart_tx = r_shreg[0];
            default: w_uart_tx = 1'b1;
        endcase
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign uart_tx_o = w_uart_tx;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_wb_uart_prog_tx.sv
// Self-checking bench for wb_uart_prog_tx: directed cases plus randomized
// frames compared against a byte-queue / waveform reference model.
module tb_wb_uart_prog_tx;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] A_TXDATA = BASE + 32'h0;
    localparam logic [31:0] A_CTRL   = BASE + 32'h4;
    localparam logic [31:0] A_STATUS = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        uart_tx_o;
    logic        irq_o;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  m_fifo[$];
    bit          m_ovf;

    wb_uart_prog_tx u_dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .uart_tx_o (uart_tx_o),
        .irq_o     (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
    endtask

    // One bus cycle; waits at most 16 clocks for ack, returns at ack-cycle + 1ns
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        int n;
        rdat  = '0;
        acked = 1'b0;
        n     = 0;
        @(posedge wb_clk_i);
        #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
        while (!acked && n < 16) begin
            @(posedge wb_clk_i);
            #1;
            n++;
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdat  = wbs_dat_o;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = '0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        logic        ak;
        wb_xfer(1'b1, adr, dat, sel, rd, ak);
        check_eq("wr_ack", {31'd0, ak}, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
        logic ak;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rdat, ak);
        check_eq("rd_ack", {31'd0, ak}, 32'd1);
        @(posedge wb_clk_i);
        #1;
        check_eq("ack_one_cycle", {31'd0, wbs_ack_o}, 32'd0);
        check_eq("dat_cleared", wbs_dat_o, 32'd0);
    endtask

    // Push while the transmitter is disabled; model keeps the FIFO as a queue
    task automatic push_byte(input logic [7:0] b, input logic [3:0] sel);
        wb_write(A_TXDATA, {24'h0, b}, sel);
        if (sel[0]) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [31:0] status_model(input int lvl, input bit ovf, input bit busy);
        return {23'd0, ovf, 4'(lvl), 1'b0, (lvl == 0), (lvl == DEPTH), busy};
    endfunction

    // Line level at cycle c of a frame: start, 8 data LSB first, stop, then idle
    function automatic logic exp_bit(input logic [7:0] b, input int bt, input int c);
        int pos;
        pos = c / bt;
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return b[pos-1];
    endfunction

    // Call right after the write that starts transmission returns
    task automatic watch_frames(input int bt, input logic exp_irq);
        int         bad;
        int         irq_bad;
        int         pos;
        logic [7:0] dec;
        logic [7:0] b;
        irq_bad = 0;
        for (int k = 0; k < m_fifo.size(); k++) begin
            b   = m_fifo[k];
            bad = 0;
            dec = 8'h00;
            for (int c = 0; c <= 10 * bt; c++) begin
                @(posedge wb_clk_i);
                #1;
                if (uart_tx_o !== exp_bit(b, bt, c)) bad++;
                if (irq_o !== 1'b0) irq_bad++;
                pos = c / bt;
                if (pos >= 1 && pos <= 8 && (c % bt) == bt / 2) dec[pos-1] = uart_tx_o;
            end
            check_eq("frame_wave", bad, 0);
            check_eq("frame_byte", {24'd0, dec}, {24'd0, b});
        end
        check_eq("irq_low_in_frames", irq_bad, 0);
        @(posedge wb_clk_i);
        #1;
        check_eq("irq_after_idle", {31'd0, irq_o}, {31'd0, exp_irq});
        check_eq("line_idle", {31'd0, uart_tx_o}, 32'd1);
        m_fifo.delete();
    endtask

    logic [31:0] rd;
    logic        ak;

    initial begin
        do_reset();
        check_eq("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check_eq("rst_dat", wbs_dat_o, 32'd0);
        check_eq("rst_tx", {31'd0, uart_tx_o}, 32'd1);
        check_eq("rst_irq", {31'd0, irq_o}, 32'd0);
        wb_read(A_STATUS, rd); check_eq("rst_status", rd, 32'h0000_0004);
        wb_read(A_CTRL, rd);   check_eq("rst_ctrl", rd, 32'h0000_0364);
        wb_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        wb_read(A_RSVD, rd);   check_eq("rsvd_read", rd, 32'h0);
        wb_read(A_TXDATA, rd); check_eq("txdata_read", rd, 32'h0);

        // 0xA5 at cpb=4
        m_fifo.delete(); m_ovf = 1'b0;
        wb_write(A_CTRL, 32'h0001_0004, 4'hF);
        wb_write(A_TXDATA, 32'h0000_00A5, 4'hF);
        check_eq("tx_high_in_ack", {31'd0, uart_tx_o}, 32'd1);
        m_fifo.push_back(8'hA5);
        watch_frames(4, 1'b0);

        // Overflow with transmitter disabled
        do_reset();
        m_fifo.delete(); m_ovf = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(8'(i), 4'hF);
        wb_read(A_STATUS, rd); check_eq("ovf_status", rd, 32'h0000_0182);
        wb_write(A_STATUS, 32'h0000_0100, 4'hF);
        wb_read(A_STATUS, rd); check_eq("ovf_cleared", rd, 32'h0000_0082);

        // cpb=0: one-cycle bits, irq after drain
        do_reset();
        m_fifo.delete(); m_ovf = 1'b0;
        push_byte(8'h00, 4'hF);
        push_byte(8'hFF, 4'hF);
        wb_write(A_CTRL, 32'h0003_0000, 4'hF);
        watch_frames(1, 1'b1);
        wb_read(A_STATUS, rd); check_eq("cpb0_status", rd, 32'h0000_0004);

        // Out-of-window access
        do_reset();
        wb_xfer(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, rd, ak);
        check_eq("miss_no_ack", {31'd0, ak}, 32'd0);
        check_eq("miss_dat", wbs_dat_o, 32'd0);
        wb_read(A_CTRL, rd);   check_eq("miss_ctrl", rd, 32'h0000_0364);
        wb_read(A_STATUS, rd); check_eq("miss_status", rd, 32'h0000_0004);

        // Reset during DATA of a 0x00 frame
        do_reset();
        wb_write(A_TXDATA, 32'h00, 4'hF);
        wb_write(A_TXDATA, 32'h11, 4'hF);
        wb_write(A_CTRL, 32'h0001_0004, 4'hF);
        repeat (6) @(posedge wb_clk_i);
        #1;
        check_eq("mid_data_low", {31'd0, uart_tx_o}, 32'd0);
        wb_rst_i = 1'b1;
        #1;
        check_eq("async_rst_tx", {31'd0, uart_tx_o}, 32'd1);
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        wb_read(A_STATUS, rd); check_eq("post_rst_status", rd, 32'h0000_0004);

        // Randomized: byte-lane CTRL writes, random bursts, random cpb/irq_en
        for (int it = 0; it < 6; it++) begin
            logic [31:0] d;
            logic [3:0]  sel;
            logic [31:0] exp_ctrl;
            logic [15:0] cpb;
            logic        ien;
            int          n;
            int          bt;
            do_reset();
            sel = 4'($urandom_range(0, 15));
            d   = $urandom;
            wb_write(A_CTRL, d, sel);
            exp_ctrl = {14'd0, sel[2] ? d[17:16] : 2'b00, sel[1] ? d[15:8] : 8'h03,
                        sel[0] ? d[7:0] : 8'h64};
            wb_read(A_CTRL, rd); check_eq("ctrl_lanes", rd, exp_ctrl);

            cpb = 16'($urandom_range(0, 3));
            bt  = (cpb == 16'd0) ? 1 : int'(cpb);
            wb_write(A_CTRL, {16'h0, cpb}, 4'hF);
            m_fifo.delete(); m_ovf = 1'b0;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                push_byte(8'($urandom), ($urandom_range(0, 3) == 0) ? 4'hE : 4'hF);
            end
            wb_read(A_STATUS, rd);
            check_eq("rand_status", rd, status_model(m_fifo.size(), m_ovf, 1'b0));

            ien = 1'($urandom_range(0, 1));
            wb_write(A_CTRL, {14'd0, ien, 1'b1, cpb}, 4'hF);
            if (m_fifo.size() == 0) begin
                @(posedge wb_clk_i);
                #1;
                check_eq("rand_empty_irq", {31'd0, irq_o}, {31'd0, ien});
            end else begin
                watch_frames(bt, ien);
            end
            wb_read(A_STATUS, rd);
            check_eq("rand_drained", rd, status_model(0, m_ovf, 1'b0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
